axil_reg_rd_resp: RTL and testbench
===================================

# axil_reg_rd_resp

AXI4-lite read responder that terminates the AR/R channels of an AXI-lite slave port and drives a simple single-cycle-strobe register read port toward local CSR logic. Sits at the leaf of an AXI-lite interconnect, behind any clock-domain crossing, in the register domain. Handles one outstanding read at a time, holds the register request until acknowledged, and optionally converts a non-responding register target into an SLVERR response.

## Interface
- DATA_WIDTH, 32, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 32, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, bytes per word; ADDR_LSB = $clog2(STRB_WIDTH)
- TIMEOUT, 4, register-ack timeout in cycles (1..255); used only when the timeout feature is compiled in
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- s_axil_araddr  input  ADDR_WIDTH  read address
- s_axil_arprot  input  3  protection type
- s_axil_arvalid  input  1  address valid
- s_axil_arready  output  1  address ready
- s_axil_rdata  output  DATA_WIDTH  read data
- s_axil_rresp  output  2  response (2'b00 OKAY, 2'b10 SLVERR)
- s_axil_rvalid  output  1  read data valid
- s_axil_rready  input  1  read data ready
- reg_rd_addr  output  ADDR_WIDTH  word-aligned register address
- reg_rd_prot  output  3  captured arprot
- reg_rd_en  output  1  read request, held until ack or timeout
- reg_rd_data  input  DATA_WIDTH  register data, valid with ack
- reg_rd_ack  input  1  register read complete

## Operation
- States: IDLE, REQ, RESP (registered).
- IDLE: s_axil_arready = 1. On arvalid && arready: capture araddr with low ADDR_LSB bits forced to 0 into reg_rd_addr, arprot into reg_rd_prot; reg_rd_en <= 1; load timeout counter with TIMEOUT-1; -> REQ.
- REQ: arready = 0; reg_rd_en held 1, reg_rd_addr/prot stable. If reg_rd_ack: rdata <= reg_rd_data, rresp <= 2'b00, rvalid <= 1, reg_rd_en <= 0, -> RESP. Otherwise counter decrements (timeout build only).
- RESP: rvalid held with stable rdata/rresp until rready; on rvalid && rready: rvalid <= 0, -> IDLE.
- reg_rd_ack outside REQ ignored; reg_rd_data sampled only on ack in REQ.
- arready derived from state only, never from arvalid or rready.
- Reset values: s_axil_arready 0 during reset, 1 the first cycle after; s_axil_rvalid 0; s_axil_rdata 0; s_axil_rresp 0; reg_rd_en 0; reg_rd_addr 0; reg_rd_prot 0; state IDLE; counter 0.
- Reset mid-transaction: in-flight read dropped, no R beat issued, reg_rd_en drops at the reset edge.

## Timing
- AR handshake at edge 0 -> reg_rd_en high from cycle 1.
- Ack sampled at edge N -> rvalid high cycle N+1; minimum AR-to-R latency 2 cycles (ack in first REQ cycle).
- R handshake at edge M -> arready high cycle M+1; maximum throughput one read per 3 cycles.
- Ack and timeout expiry in the same cycle: ack wins, OKAY with register data.
- rready held high before rvalid: handshake completes on first rvalid cycle.

## Configuration
- Macro AXIL_REG_RD_RESP_TIMEOUT_EN.
- Defined: in REQ, if counter == 0 and no ack -> rdata <= 0, rresp <= 2'b10, rvalid <= 1, reg_rd_en <= 0, -> RESP. reg_rd_en is high exactly TIMEOUT cycles on a timed-out read. Counter width $clog2(TIMEOUT+1).
- Not defined: no counter logic; REQ waits indefinitely for reg_rd_ack; TIMEOUT ignored; rresp always 2'b00.

## Test plan
- Reset then araddr=0x0000_0013, arprot=3'b010, ack first REQ cycle with data 0xDEADBEEF, rready=1 -> reg_rd_addr=0x0000_0010, reg_rd_prot=3'b010, rvalid 2 cycles after AR, rdata=0xDEADBEEF, rresp=00.
- Ack delayed 3 cycles, rready held low 5 cycles after rvalid -> reg_rd_en high 4 cycles; rvalid/rdata stable all 5 cycles; arready 0 until the cycle after R handshake.
- Timeout build, TIMEOUT=4, no ack -> reg_rd_en high exactly 4 cycles, rresp=10, rdata=0; non-timeout build: no response after 100 cycles, reg_rd_en still 1.
- Timeout build, ack asserted on the 4th REQ cycle with data 0x1234_5678 -> rresp=00, rdata=0x1234_5678.
- rst asserted for 1 cycle while in REQ and again while in RESP -> rvalid=0, reg_rd_en=0 next cycle, arready=1 the cycle after; following read with data 0xA5A5A5A5 completes normally.
- Back-to-back arvalid held high with 4 reads and random rready stalls -> exactly 4 R beats in order, spurious reg_rd_ack pulses in IDLE/RESP ignored.

Source files
------------

// File: rtl/axil_reg_rd_resp_if.sv
// Purpose : bundles the AXI4-lite AR/R channels and the local register read port of axil_reg_rd_resp.
// Latency : none (signal container only).
// Backpressure: arready/rready on AXI side; the register port has no backpressure, only ack.
// Ports   : s_axil_ar*/s_axil_r* AXI-lite read channels, reg_rd_* register read request/response.
// Modports: slave = responder (the DUT), master = AXI initiator plus register target (the environment).
interface axil_reg_rd_resp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic [2:0]            s_axil_arprot;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [DATA_WIDTH-1:0] s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;
    logic [ADDR_WIDTH-1:0] reg_rd_addr;
    logic [2:0]            reg_rd_prot;
    logic                  reg_rd_en;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  reg_rd_ack;

    modport slave (
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
        input  reg_rd_data, reg_rd_ack,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output reg_rd_addr, reg_rd_prot, reg_rd_en
    );

    modport master (
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
        output reg_rd_data, reg_rd_ack,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  reg_rd_addr, reg_rd_prot, reg_rd_en
    );
endinterface

// File: rtl/axil_reg_rd_resp.sv
// Purpose : AXI4-lite read responder; turns one AR beat into a held register read request and returns one R beat.
// Latency : AR handshake -> reg_rd_en next cycle; ack -> rvalid next cycle (min AR-to-R 2 cycles, 1 read / 3 cycles).
// Backpressure: one read outstanding; arready low from AR accept until the R beat is taken; rvalid/rdata held until rready.
// Ports   : clk, rst (synchronous, active-high); bus = axil_reg_rd_resp_if.slave carrying AR/R and the reg_rd_* port.
// Option  : define AXIL_REG_RD_RESP_TIMEOUT_EN to answer SLVERR (rdata 0) when the register target does not
//           ack within TIMEOUT cycles; without it the request waits for ack indefinitely and rresp is always OKAY.
module axil_reg_rd_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                clk,
    input  logic                rst,
    axil_reg_rd_resp_if.slave   bus
);
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LSB_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Elaboration guard on the configuration range.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("axil_reg_rd_resp: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [2:0]            rd_prot_q;
    logic                  rd_en_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rvalid_q;
    logic                  arready;

`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    // arready is a pure function of state; it is also forced low while rst is
    // asserted so no address is accepted in a cycle that is being reset.
    assign arready = (state_q == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_prot_q <= '0;
            rd_en_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.s_axil_arvalid && arready) begin
                        // Register targets decode whole words, so drop the byte offset.
                        rd_addr_q <= bus.s_axil_araddr & ~ADDR_LSB_MASK;
                        rd_prot_q <= bus.s_axil_arprot;
                        rd_en_q   <= 1'b1;
`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
                        // Counts down through the REQ cycles; zero marks the last one.
                        cnt_q     <= CNT_W'(TIMEOUT - 1);
`endif
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack in the final allowed cycle still returns data.
                    if (bus.reg_rd_ack) begin
                        rdata_q  <= bus.reg_rd_data;
                        rresp_q  <= RESP_OKAY;
                        rvalid_q <= 1'b1;
                        rd_en_q  <= 1'b0;
                        state_q  <= RESP;
                    end
`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rvalid_q <= 1'b1;
                        rd_en_q  <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.s_axil_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rd_en_q  <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_axil_arready = arready;
    assign bus.s_axil_rdata   = rdata_q;
    assign bus.s_axil_rresp   = rresp_q;
    assign bus.s_axil_rvalid  = rvalid_q;
    assign bus.reg_rd_addr    = rd_addr_q;
    assign bus.reg_rd_prot    = rd_prot_q;
    assign bus.reg_rd_en      = rd_en_q;
endmodule

// File: tb/tb_axil_reg_rd_resp.sv
// Purpose : self-checking bench for axil_reg_rd_resp: vector table, reset/timeout sequences, randomized scoreboard run.
// Latency : n/a.
// Backpressure: bench drives random rready stalls and a register target with random ack delays.
module tb_axil_reg_rd_resp;
    localparam int TIMEOUT = 4;
    localparam int NOACK   = 1000;
    localparam int NRAND   = 24;
    localparam logic [31:0] KEY = 32'h5A3C_96E1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    axil_reg_rd_resp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    axil_reg_rd_resp #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One complete read: AR at the next edge, register ack after ack_dly extra REQ
    // cycles, rready held low rr_dly cycles after rvalid (spurious acks sent meanwhile).
    task automatic run_read(
        input  logic [31:0] addr, input logic [2:0] prot, input int ack_dly,
        input  logic [31:0] data, input int rr_dly, input bit rr_early,
        output logic [31:0] o_addr, output logic [2:0] o_prot, output int o_lat,
        output int o_en, output logic [31:0] o_rdata, output logic [1:0] o_resp,
        output bit o_stable, output bit o_ok_after);
        int n;
        bit acked;
        o_stable = 1'b1;
        if (bus.s_axil_arready !== 1'b1) o_stable = 1'b0;
        bus.s_axil_araddr  = addr;
        bus.s_axil_arprot  = prot;
        bus.s_axil_arvalid = 1'b1;
        bus.s_axil_rready  = rr_early;
        tick();
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_araddr  = $urandom;
        bus.s_axil_arprot  = 3'($urandom);
        o_addr = bus.reg_rd_addr;
        o_prot = bus.reg_rd_prot;
        n = 1; o_en = 0; acked = 1'b0;
        while (!bus.s_axil_rvalid && n < 200) begin
            if (bus.reg_rd_en) begin
                o_en++;
                if (bus.reg_rd_addr !== o_addr || bus.reg_rd_prot !== o_prot || bus.s_axil_arready !== 1'b0)
                    o_stable = 1'b0;
            end
            if (!acked && o_en == ack_dly + 1) begin
                bus.reg_rd_ack  = 1'b1;
                bus.reg_rd_data = data;
                acked = 1'b1;
            end
            tick();
            bus.reg_rd_ack  = 1'b0;
            bus.reg_rd_data = $urandom;
            n++;
        end
        o_lat   = n;
        o_rdata = bus.s_axil_rdata;
        o_resp  = bus.s_axil_rresp;
        for (int k = 0; k < rr_dly; k++) begin
            bus.reg_rd_ack  = 1'b1;
            bus.reg_rd_data = $urandom;
            tick();
            bus.reg_rd_ack = 1'b0;
            if (!bus.s_axil_rvalid || bus.s_axil_rdata !== o_rdata || bus.s_axil_rresp !== o_resp ||
                bus.s_axil_arready !== 1'b0)
                o_stable = 1'b0;
        end
        bus.s_axil_rready = 1'b1;
        tick();
        bus.s_axil_rready = 1'b0;
        o_ok_after = !bus.s_axil_rvalid && bus.s_axil_arready && !bus.reg_rd_en;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
        int          ack_dly;
        logic [31:0] data;
        int          rr_dly;
        bit          rr_early;
        logic [31:0] exp_addr;
        int          exp_lat;
        int          exp_en;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    vec_t        vecs[5];
    beat_t       exp_q[$];
    beat_t       e;
    logic [31:0] r_addr[NRAND];
    logic [2:0]  r_prot[NRAND];
    int          r_dly[NRAND];

    logic [31:0] o_addr, o_rdata;
    logic [2:0]  o_prot;
    logic [1:0]  o_resp;
    int          o_lat, o_en;
    bit          o_stable, o_ok;
    int          issued, beats, wait_cnt, dly_max, cnt_a, cnt_b;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        // addr, prot, ack_dly, data, rr_dly, rr_early -> exp_addr, exp_lat, exp_en, exp_rdata, exp_resp
        vecs[0] = '{32'h0000_0013, 3'b010, 0, 32'hDEAD_BEEF, 0, 1'b1, 32'h0000_0010, 2, 1, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h0000_0104, 3'b101, 3, 32'hCAFE_F00D, 5, 1'b0, 32'h0000_0104, 5, 4, 32'hCAFE_F00D, 2'b00};
        vecs[2] = '{32'hFFFF_FFFF, 3'b111, 1, 32'h0000_0001, 2, 1'b0, 32'hFFFF_FFFC, 3, 2, 32'h0000_0001, 2'b00};
        vecs[3] = '{32'h8000_0002, 3'b000, 3, 32'h1234_5678, 0, 1'b1, 32'h8000_0000, 5, 4, 32'h1234_5678, 2'b00};
        vecs[4] = '{32'h0000_0ABF, 3'b001, 2, 32'hFFFF_FFFF, 1, 1'b0, 32'h0000_0ABC, 4, 3, 32'hFFFF_FFFF, 2'b00};

        rst = 1'b1;
        bus.s_axil_araddr  = '0;
        bus.s_axil_arprot  = '0;
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready  = 1'b0;
        bus.reg_rd_data    = '0;
        bus.reg_rd_ack     = 1'b0;
        tick();
        tick();
        check("rst_arready", 64'(bus.s_axil_arready), 64'd0);
        check("rst_rvalid",  64'(bus.s_axil_rvalid),  64'd0);
        check("rst_rdata",   64'(bus.s_axil_rdata),   64'd0);
        check("rst_rresp",   64'(bus.s_axil_rresp),   64'd0);
        check("rst_en",      64'(bus.reg_rd_en),      64'd0);
        check("rst_addr",    64'(bus.reg_rd_addr),    64'd0);
        check("rst_prot",    64'(bus.reg_rd_prot),    64'd0);
        rst = 1'b0;
        #1;
        check("rst_arready_after", 64'(bus.s_axil_arready), 64'd1);
        tick();

        // Vector table.
        for (int i = 0; i < 5; i++) begin
            run_read(vecs[i].addr, vecs[i].prot, vecs[i].ack_dly, vecs[i].data, vecs[i].rr_dly,
                     vecs[i].rr_early, o_addr, o_prot, o_lat, o_en, o_rdata, o_resp, o_stable, o_ok);
            check($sformatf("v%0d_addr", i),   64'(o_addr),   64'(vecs[i].exp_addr));
            check($sformatf("v%0d_prot", i),   64'(o_prot),   64'(vecs[i].prot));
            check($sformatf("v%0d_lat", i),    64'(o_lat),    64'(vecs[i].exp_lat));
            check($sformatf("v%0d_en", i),     64'(o_en),     64'(vecs[i].exp_en));
            check($sformatf("v%0d_rdata", i),  64'(o_rdata),  64'(vecs[i].exp_rdata));
            check($sformatf("v%0d_rresp", i),  64'(o_resp),   64'(vecs[i].exp_resp));
            check($sformatf("v%0d_stable", i), 64'(o_stable), 64'd1);
            check($sformatf("v%0d_after", i),  64'(o_ok),     64'd1);
        end

`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
        // Silent register target: SLVERR with zero data after exactly TIMEOUT request cycles.
        run_read(32'h0000_0047, 3'b100, NOACK, 32'hBAD0_BAD0, 2, 1'b0,
                 o_addr, o_prot, o_lat, o_en, o_rdata, o_resp, o_stable, o_ok);
        check("to_addr",   64'(o_addr),   64'h44);
        check("to_lat",    64'(o_lat),    64'(TIMEOUT + 1));
        check("to_en",     64'(o_en),     64'(TIMEOUT));
        check("to_rdata",  64'(o_rdata),  64'd0);
        check("to_rresp",  64'(o_resp),   64'h2);
        check("to_stable", 64'(o_stable), 64'd1);
        check("to_after",  64'(o_ok),     64'd1);
        dly_max = TIMEOUT + 1;
`else
        // Silent register target: request simply stays up.
        bus.s_axil_araddr  = 32'h0000_0047;
        bus.s_axil_arprot  = 3'b100;
        bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.reg_rd_en) cnt_a++;
            if (bus.s_axil_rvalid) cnt_b++;
            tick();
        end
        check("noto_en_cycles", 64'(cnt_a), 64'd100);
        check("noto_rvalid",    64'(cnt_b), 64'd0);
        check("noto_en_still",  64'(bus.reg_rd_en), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        dly_max = 3;
`endif

        // Reset while in REQ.
        bus.s_axil_araddr  = 32'h0000_0108;
        bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        check("rq_en_before", 64'(bus.reg_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        check("rq_arready_in_rst", 64'(bus.s_axil_arready), 64'd0);
        tick();
        rst = 1'b0;
        check("rq_rvalid", 64'(bus.s_axil_rvalid), 64'd0);
        check("rq_en",     64'(bus.reg_rd_en),     64'd0);
        check("rq_addr",   64'(bus.reg_rd_addr),   64'd0);
        tick();
        check("rq_arready", 64'(bus.s_axil_arready), 64'd1);
        check("rq_no_beat", 64'(bus.s_axil_rvalid),  64'd0);

        // Reset while in RESP.
        bus.s_axil_araddr  = 32'h0000_010C;
        bus.s_axil_arvalid = 1'b1;
        tick();
        bus.s_axil_arvalid = 1'b0;
        bus.reg_rd_ack     = 1'b1;
        bus.reg_rd_data    = 32'h0BAD_CAFE;
        tick();
        bus.reg_rd_ack = 1'b0;
        check("rs_rvalid_before", 64'(bus.s_axil_rvalid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_rvalid", 64'(bus.s_axil_rvalid), 64'd0);
        check("rs_rdata",  64'(bus.s_axil_rdata),  64'd0);
        check("rs_en",     64'(bus.reg_rd_en),     64'd0);
        tick();
        check("rs_arready", 64'(bus.s_axil_arready), 64'd1);
        check("rs_no_beat", 64'(bus.s_axil_rvalid),  64'd0);

        run_read(32'h0000_0200, 3'b000, 1, 32'hA5A5_A5A5, 0, 1'b1,
                 o_addr, o_prot, o_lat, o_en, o_rdata, o_resp, o_stable, o_ok);
        check("post_rst_rdata", 64'(o_rdata), 64'hA5A5_A5A5);
        check("post_rst_rresp", 64'(o_resp),  64'd0);
        check("post_rst_lat",   64'(o_lat),   64'd3);
        check("post_rst_after", 64'(o_ok),    64'd1);

        // Randomized back-to-back reads. Reference: every accepted address yields
        // exactly one beat, in order, carrying the target's data for the word
        // address (target returns addr ^ KEY), or SLVERR/0 when the target's
        // delay reaches TIMEOUT in the timeout build.
        for (int i = 0; i < NRAND; i++) begin
            r_addr[i] = $urandom;
            r_prot[i] = 3'($urandom);
            r_dly[i]  = $urandom_range(0, dly_max);
        end
        issued   = 0;
        beats    = 0;
        wait_cnt = 0;
        for (int cyc = 0; cyc < 3000 && beats < NRAND; cyc++) begin
            bus.s_axil_arvalid = (issued < NRAND);
            if (issued < NRAND) begin
                bus.s_axil_araddr = r_addr[issued];
                bus.s_axil_arprot = r_prot[issued];
            end
            bus.s_axil_rready = ($urandom_range(0, 2) != 0);
            if (bus.reg_rd_en && issued > 0) begin
                if (wait_cnt == r_dly[issued-1]) begin
                    bus.reg_rd_ack  = 1'b1;
                    bus.reg_rd_data = bus.reg_rd_addr ^ KEY;
                    check("rand_prot", 64'(bus.reg_rd_prot), 64'(r_prot[issued-1]));
                end else begin
                    bus.reg_rd_ack  = 1'b0;
                    bus.reg_rd_data = $urandom;
                end
            end else begin
                bus.reg_rd_ack  = ($urandom_range(0, 3) == 0);
                bus.reg_rd_data = $urandom;
            end
            if (bus.s_axil_rvalid && bus.s_axil_rready) begin
                if (exp_q.size() == 0) begin
                    check("rand_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand%0d_rdata", beats), 64'(bus.s_axil_rdata), 64'(e.data));
                    check($sformatf("rand%0d_rresp", beats), 64'(bus.s_axil_rresp), 64'(e.resp));
                end
                beats++;
            end
            if (bus.s_axil_arvalid && bus.s_axil_arready) begin
                e.data = (r_addr[issued] & ~32'h3) ^ KEY;
                e.resp = 2'b00;
`ifdef AXIL_REG_RD_RESP_TIMEOUT_EN
                if (r_dly[issued] >= TIMEOUT) begin
                    e.data = '0;
                    e.resp = 2'b10;
                end
`endif
                exp_q.push_back(e);
                issued++;
                wait_cnt = 0;
            end else if (bus.reg_rd_en) begin
                wait_cnt++;
            end
            tick();
            bus.reg_rd_ack = 1'b0;
        end
        bus.s_axil_arvalid = 1'b0;
        check("rand_beats",   64'(beats), 64'(NRAND));
        check("rand_pending", 64'(exp_q.size()), 64'd0);
        bus.s_axil_rready = 1'b1;
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin
            bus.reg_rd_ack = 1'b1;
            if (bus.s_axil_rvalid) cnt_a++;
            tick();
        end
        bus.reg_rd_ack = 1'b0;
        check("rand_tail_quiet", 64'(cnt_a), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
